ysyx_22050039_decode_stage: RTL and testbench

YSYX_22050039_DECODE_STAGE -- requirements
Module: ysyx_22050039_decode_stage

---
 rtl/ysyx_22050039_pkg.sv | 57 +++++
 rtl/ysyx_22050039_decode_stage_if.sv | 41 ++++
 rtl/ysyx_22050039_regfile.sv | 30 +++
 rtl/ysyx_22050039_decode_stage.sv | 127 ++++++++++++
 tb/tb_ysyx_22050039_decode_stage.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22050039_pkg.sv
// Shared decode constants: func codes, RV64 opcodes, one-hot instruction
// formats and a pure decode helper used by the decode stage.
package ysyx_22050039_pkg;

  localparam logic [2:0] FUNC_ADDI    = 3'd0;
  localparam logic [2:0] FUNC_JALR    = 3'd1;
  localparam logic [2:0] FUNC_AUIPC   = 3'd2;
  localparam logic [2:0] FUNC_LUI     = 3'd3;
  localparam logic [2:0] FUNC_SD      = 3'd4;
  localparam logic [2:0] FUNC_JAL     = 3'd5;
  localparam logic [2:0] FUNC_EBREAK  = 3'd6;
  localparam logic [2:0] FUNC_ILLEGAL = 3'd7;

  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_JAL   = 7'h6f;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic [4:0] {
    TYPE_NONE = 5'b00001,
    TYPE_I    = 5'b00010,
    TYPE_S    = 5'b00100,
    TYPE_U    = 5'b01000,
    TYPE_J    = 5'b10000
  } inst_type_e;

  typedef struct packed {
    logic [2:0] func;
    inst_type_e itype;
  } decode_t;

  // ebreak shares the I-format encoding but reads no registers, so it is TYPE_NONE.
  function automatic decode_t decode_inst(input logic [31:0] inst);
    decode_t d;
    d.func  = FUNC_ILLEGAL;
    d.itype = TYPE_NONE;
    if (inst == INST_EBREAK) begin
      d.func = FUNC_EBREAK;
    end else begin
      case (inst[6:0])
        OP_IMM:   if (inst[14:12] == 3'b000) begin d.func = FUNC_ADDI; d.itype = TYPE_I; end
        OP_JALR:  if (inst[14:12] == 3'b000) begin d.func = FUNC_JALR; d.itype = TYPE_I; end
        OP_AUIPC: begin d.func = FUNC_AUIPC; d.itype = TYPE_U; end
        OP_LUI:   begin d.func = FUNC_LUI;   d.itype = TYPE_U; end
        OP_STORE: if (inst[14:12] == 3'b011) begin d.func = FUNC_SD; d.itype = TYPE_S; end
        OP_JAL:   begin d.func = FUNC_JAL;   d.itype = TYPE_J; end
        default:  ;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/ysyx_22050039_decode_stage_if.sv
// Fetch-side input, execute-side output and write-back port of the decode stage.
// Handshake: a beat moves on a rising edge where valid & ready are both high;
// valid never waits on ready, and payload is held stable while valid & !ready.
interface ysyx_22050039_decode_stage_if #(
  parameter int XLEN     = 64,
  parameter int INST_LEN = 32,
  parameter int REG_SEL  = 5
);
  logic                in_valid;
  logic                in_ready;
  logic [INST_LEN-1:0] inst;
  logic [XLEN-1:0]     pc;

  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_src1;
  logic [XLEN-1:0]     out_src2;
  logic [XLEN-1:0]     out_imm;
  logic [XLEN-1:0]     out_pc;
  logic [REG_SEL-1:0]  out_rd;
  logic                out_rd_wen;
  logic [2:0]          out_func;
  logic                out_pc_wen;
  logic                out_illegal;

  logic                wb_en;
  logic [REG_SEL-1:0]  wb_rd;
  logic [XLEN-1:0]     wb_data;

  modport master (
    output in_valid, inst, pc, out_ready, wb_en, wb_rd, wb_data,
    input  in_ready, out_valid, out_src1, out_src2, out_imm, out_pc,
           out_rd, out_rd_wen, out_func, out_pc_wen, out_illegal
  );

  modport slave (
    input  in_valid, inst, pc, out_ready, wb_en, wb_rd, wb_data,
    output in_ready, out_valid, out_src1, out_src2, out_imm, out_pc,
           out_rd, out_rd_wen, out_func, out_pc_wen, out_illegal
  );
endinterface

// File: rtl/ysyx_22050039_regfile.sv
// General purpose register file: two combinational read ports, one write port;
// x0 always reads zero and ignores writes.
module ysyx_22050039_regfile #(
  parameter int XLEN    = 64,
  parameter int NR_REG  = 32,
  parameter int REG_SEL = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [REG_SEL-1:0] waddr,
  input  logic [XLEN-1:0]    wdata,
  input  logic [REG_SEL-1:0] raddr1,
  output logic [XLEN-1:0]    rdata1,
  input  logic [REG_SEL-1:0] raddr2,
  output logic [XLEN-1:0]    rdata2
);
  logic [XLEN-1:0] gpr [NR_REG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR_REG; i++) gpr[i] <= '0;
    end else if (we && (waddr != '0)) begin
      gpr[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : gpr[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : gpr[raddr2];
endmodule

// File: rtl/ysyx_22050039_decode_stage.sv
// Decode stage: one registered bundle, busy-bit scoreboard for RAW hazards.
// Define YSYX_22050039_WB_BYPASS_EN to forward same-cycle write-back data to operands.
module ysyx_22050039_decode_stage
  import ysyx_22050039_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int INST_LEN = 32,
  parameter int NR_REG   = 32,
  parameter int REG_SEL  = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  ysyx_22050039_decode_stage_if.slave bus,
  output logic [NR_REG-1:0]           busy
);
  logic [INST_LEN-1:0] inst;
  logic [REG_SEL-1:0]  rs1, rs2, rd;
  decode_t             dec;
  logic [XLEN-1:0]     imm, rdata1, rdata2, opnd1, opnd2, src1_d, src2_d;
  logic                byp1, byp2, rs1_used, rs2_used, hazard;
  logic                rd_wen_d, pc_wen_d, in_fire, out_fire;
  logic [NR_REG-1:0]   busy_q, busy_d;

  assign inst = bus.inst;
  assign rd   = inst[11:7];
  assign rs1  = inst[19:15];
  assign rs2  = inst[24:20];
  assign dec  = decode_inst(inst[31:0]);

  always_comb begin
    imm = '0;
    case (dec.itype)
      TYPE_I:  imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
      TYPE_S:  imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
      TYPE_U:  imm = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
      TYPE_J:  imm = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  ysyx_22050039_regfile #(.XLEN(XLEN), .NR_REG(NR_REG), .REG_SEL(REG_SEL)) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (bus.wb_en),
    .waddr  (bus.wb_rd),
    .wdata  (bus.wb_data),
    .raddr1 (rs1),
    .rdata1 (rdata1),
    .raddr2 (rs2),
    .rdata2 (rdata2)
  );

`ifdef YSYX_22050039_WB_BYPASS_EN
  assign byp1 = bus.wb_en && (bus.wb_rd == rs1) && (rs1 != '0);
  assign byp2 = bus.wb_en && (bus.wb_rd == rs2) && (rs2 != '0);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign opnd1    = byp1 ? bus.wb_data : rdata1;
  assign opnd2    = byp2 ? bus.wb_data : rdata2;
  assign rs1_used = (dec.itype == TYPE_I) || (dec.itype == TYPE_S);
  assign rs2_used = (dec.itype == TYPE_S);
  assign hazard   = (rs1_used && busy_q[rs1] && !byp1) || (rs2_used && busy_q[rs2] && !byp2);

  assign rd_wen_d = (dec.func inside {FUNC_ADDI, FUNC_JALR, FUNC_AUIPC, FUNC_LUI, FUNC_JAL})
                    && (rd != '0);
  assign pc_wen_d = (dec.func == FUNC_JAL) || (dec.func == FUNC_JALR);

  always_comb begin
    src1_d = '0;
    src2_d = '0;
    case (dec.itype)
      TYPE_I:         begin src1_d = opnd1; src2_d = imm;   end
      TYPE_S:         begin src1_d = opnd1; src2_d = opnd2; end
      TYPE_U, TYPE_J: src1_d = imm;
      default:        ;
    endcase
  end

  assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !hazard;
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign out_fire     = bus.out_valid && bus.out_ready;

  // A new destination claimed this cycle outranks a write-back retiring the same index.
  always_comb begin
    busy_d = busy_q;
    if (bus.wb_en) busy_d[bus.wb_rd] = 1'b0;
    if (in_fire && rd_wen_d) busy_d[rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid   <= 1'b0;
      bus.out_src1    <= '0;
      bus.out_src2    <= '0;
      bus.out_imm     <= '0;
      bus.out_pc      <= '0;
      bus.out_rd      <= '0;
      bus.out_rd_wen  <= 1'b0;
      bus.out_func    <= '0;
      bus.out_pc_wen  <= 1'b0;
      bus.out_illegal <= 1'b0;
      busy_q          <= '0;
    end else begin
      if (in_fire) begin
        bus.out_valid   <= 1'b1;
        bus.out_src1    <= src1_d;
        bus.out_src2    <= src2_d;
        bus.out_imm     <= imm;
        bus.out_pc      <= bus.pc;
        bus.out_rd      <= rd;
        bus.out_rd_wen  <= rd_wen_d;
        bus.out_func    <= dec.func;
        bus.out_pc_wen  <= pc_wen_d;
        bus.out_illegal <= (dec.func == FUNC_ILLEGAL);
      end else if (out_fire) begin
        bus.out_valid <= 1'b0;
      end
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
endmodule

// File: tb/tb_ysyx_22050039_decode_stage.sv
// Bench for the decode stage: directed scenarios plus random traffic, scored
// against an instruction-level model of registers, busy bits and the output slot.
module tb_ysyx_22050039_decode_stage;
  localparam int XLEN = 64, INST_LEN = 32, NR_REG = 32, REG_SEL = 5;

  typedef struct packed {
    logic [2:0]  func;
    logic        illegal;
    logic        pc_wen;
    logic        rd_wen;
    logic [4:0]  rd;
    logic [63:0] src1;
    logic [63:0] src2;
    logic [63:0] imm;
    logic [63:0] pc;
  } bundle_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR_REG-1:0] busy;

  ysyx_22050039_decode_stage_if #(.XLEN(XLEN), .INST_LEN(INST_LEN), .REG_SEL(REG_SEL)) bus ();

  ysyx_22050039_decode_stage #(
    .XLEN(XLEN), .INST_LEN(INST_LEN), .NR_REG(NR_REG), .REG_SEL(REG_SEL)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  logic [$bits(bundle_t)-1:0] exp_q[$];
  logic [63:0] m_gpr [32];
  logic [31:0] m_busy;
  bit          m_ov;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit fwd(input logic [4:0] idx);
`ifdef YSYX_22050039_WB_BYPASS_EN
    return bus.wb_en && (bus.wb_rd == idx) && (idx != 5'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [63:0] op_val(input logic [4:0] idx);
    if (idx == 5'd0) return 64'd0;
    if (fwd(idx)) return bus.wb_data;
    return m_gpr[idx];
  endfunction

  // Instruction-level reference: classify, build the immediate arithmetically, pick operands.
  function automatic bundle_t model_bundle(input logic [31:0] i, input logic [63:0] pc,
                                           input logic [63:0] v1, input logic [63:0] v2,
                                           output bit use1, output bit use2);
    bundle_t b;
    longint imm_i, imm_s, imm_u, imm_j;
    logic [20:0] j;
    logic [6:0] opc;
    logic [2:0] f3;
    b = '0;
    b.pc = pc;
    b.rd = i[11:7];
    use1 = 1'b0;
    use2 = 1'b0;
    opc = i[6:0];
    f3 = i[14:12];
    imm_i = longint'($signed(i)) >>> 20;
    imm_s = ((longint'($signed(i)) >>> 25) <<< 5) | longint'(i[11:7]);
    imm_u = longint'($signed(i & 32'hFFFF_F000));
    j = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    imm_j = (longint'(j) <<< 43) >>> 43;
    if (i == 32'h0010_0073) begin
      b.func = 3'd6;
    end else if ((opc == 7'h13 || opc == 7'h67) && f3 == 3'd0) begin
      b.func = (opc == 7'h13) ? 3'd0 : 3'd1;
      b.pc_wen = (opc == 7'h67);
      b.imm = imm_i; b.src1 = v1; b.src2 = imm_i; use1 = 1'b1;
    end else if (opc == 7'h17 || opc == 7'h37) begin
      b.func = (opc == 7'h17) ? 3'd2 : 3'd3;
      b.imm = imm_u; b.src1 = imm_u;
    end else if (opc == 7'h23 && f3 == 3'd3) begin
      b.func = 3'd4;
      b.imm = imm_s; b.src1 = v1; b.src2 = v2; use1 = 1'b1; use2 = 1'b1;
    end else if (opc == 7'h6f) begin
      b.func = 3'd5; b.pc_wen = 1'b1;
      b.imm = imm_j; b.src1 = imm_j;
    end else begin
      b.func = 3'd7; b.illegal = 1'b1;
    end
    b.rd_wen = (b.func inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd5}) && (b.rd != 5'd0);
    return b;
  endfunction

  // One clock of stimulus; the model decides acceptance and updates at the edge.
  task automatic cycle(input bit iv, input logic [31:0] ins, input logic [63:0] p,
                       input bit ordy, input bit we, input logic [4:0] wrd,
                       input logic [63:0] wd, output bit fired);
    bundle_t b;
    bit u1, u2, haz, exp_rdy;
    logic [4:0] r1, r2;
    bus.in_valid = iv; bus.inst = ins; bus.pc = p; bus.out_ready = ordy;
    bus.wb_en = we; bus.wb_rd = wrd; bus.wb_data = wd;
    @(negedge clk);
    r1 = ins[19:15];
    r2 = ins[24:20];
    b = model_bundle(ins, p, op_val(r1), op_val(r2), u1, u2);
    haz = (u1 && r1 != 5'd0 && m_busy[r1] && !fwd(r1)) ||
          (u2 && r2 != 5'd0 && m_busy[r2] && !fwd(r2));
    exp_rdy = (!m_ov || ordy) && !haz;
    chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
    chk("busy", 64'(busy), 64'(m_busy));
    fired = iv && exp_rdy;
    @(posedge clk);
    if (we && wrd != 5'd0) m_gpr[wrd] = wd;
    if (we) m_busy[wrd] = 1'b0;
    if (fired && b.rd_wen) m_busy[b.rd] = 1'b1;
    if (fired) exp_q.push_back(b);
    m_ov = fired || (m_ov && !ordy);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.wb_en = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 64'hDEAD_BEEF;
    repeat (n) @(posedge clk);
    for (int k = 0; k < 32; k++) m_gpr[k] = 64'd0;
    m_busy = '0;
    m_ov = 1'b0;
    exp_q.delete();
    #1 rst = 1'b0;
    bus.wb_en = 1'b0;
  endtask

  function automatic logic [31:0] gen_inst();
    logic [4:0] rd, rs1, rs2;
    logic [11:0] i12;
    logic [19:0] i20;
    rd = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    i12 = 12'($urandom);
    i20 = 20'($urandom);
    case ($urandom_range(0, 7))
      0: return {i12, rs1, 3'b000, rd, 7'h13};
      1: return {i12, rs1, 3'b000, rd, 7'h67};
      2: return {i20, rd, 7'h17};
      3: return {i20, rd, 7'h37};
      4: return {i12[11:5], rs2, rs1, 3'b011, i12[4:0], 7'h23};
      5: return {i20, rd, 7'h6f};
      6: return 32'h0010_0073;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every held bundle is compared with the queue head; pop on transfer.
  always @(negedge clk) begin
    bundle_t a, e;
    if (!rst && bus.out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL bundle_unexpected: got out_valid=1 expected no bundle at %0t", $time);
      end else begin
        e = bundle_t'(exp_q[0]);
        a.func = bus.out_func; a.illegal = bus.out_illegal; a.pc_wen = bus.out_pc_wen;
        a.rd_wen = bus.out_rd_wen; a.rd = bus.out_rd; a.src1 = bus.out_src1;
        a.src2 = bus.out_src2; a.imm = bus.out_imm; a.pc = bus.out_pc;
        if (!e.rd_wen) begin a.rd = '0; e.rd = '0; end
        if (e.func >= 3'd6) begin a.imm = '0; e.imm = '0; end
        if (a !== e) begin
          errors++;
          $display("FAIL %s: got %h expected %h at %0t",
                   bus.out_ready ? "bundle" : "bundle_hold", a, e, $time);
        end
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    bit f;
    logic [4:0] wr;
    bus.in_valid = 1'b0; bus.inst = '0; bus.pc = '0; bus.out_ready = 1'b0;
    bus.wb_en = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    do_reset(2);

    // addi x1,x0,5 then dependent addi x2,x1,1 stalled until x1 is written back
    cycle(1, 32'h0050_0093, 64'h8000_0000, 1, 0, 5'd0, 64'd0, f);
    cycle(1, 32'h0010_8113, 64'h8000_0004, 1, 0, 5'd0, 64'd0, f);
    cycle(1, 32'h0010_8113, 64'h8000_0004, 1, 0, 5'd0, 64'd0, f);
    cycle(1, 32'h0010_8113, 64'h8000_0004, 1, 1, 5'd1, 64'd7, f);
    if (!f) cycle(1, 32'h0010_8113, 64'h8000_0004, 1, 0, 5'd0, 64'd0, f);
    cycle(1, 32'hFFDF_F0EF, 64'h8000_0008, 1, 1, 5'd2, 64'd8, f);
    cycle(0, 32'h0, 64'h0, 1, 1, 5'd1, 64'h1234, f);

    // back-pressure for three cycles with a new instruction waiting
    cycle(1, 32'h0010_0293, 64'h8000_0010, 0, 0, 5'd0, 64'd0, f);
    repeat (3) cycle(1, 32'h0010_0073, 64'h8000_0014, 0, 0, 5'd0, 64'd0, f);
    cycle(1, 32'h0010_0073, 64'h8000_0014, 1, 0, 5'd0, 64'd0, f);
    cycle(1, 32'hFFFF_FFFF, 64'h8000_0018, 1, 1, 5'd5, 64'd3, f);
    cycle(0, 32'h0, 64'h0, 1, 0, 5'd0, 64'd0, f);

    // reset while a bundle is held and x3 is busy, after x3 held a nonzero value
    cycle(1, 32'h0090_0193, 64'h8000_0020, 1, 0, 5'd0, 64'd0, f);
    cycle(0, 32'h0, 64'h0, 1, 1, 5'd3, 64'h55, f);
    cycle(1, 32'h0090_0193, 64'h8000_0024, 0, 0, 5'd0, 64'd0, f);
    cycle(0, 32'h0, 64'h0, 0, 0, 5'd0, 64'd0, f);
    do_reset(1);
    cycle(1, 32'h0001_8213, 64'h8000_0028, 1, 0, 5'd0, 64'd0, f);
    cycle(0, 32'h0, 64'h0, 1, 1, 5'd4, 64'd0, f);

    repeat (400) begin
      wr = 5'($urandom_range(0, 7));
      for (int k = 1; k < 8; k++) if (m_busy[k] && $urandom_range(0, 1) == 1) wr = 5'(k);
      cycle($urandom_range(0, 9) < 8, gen_inst(), {$urandom, $urandom},
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, wr, {$urandom, $urandom}, f);
    end

    repeat (3) cycle(0, 32'h0, 64'h0, 1, 0, 5'd0, 64'd0, f);
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
